wave_synth_core: RTL and testbench

// Sample-generation stage directly downstream of the UART command decoder in tt_um_waves.

---
 rtl/wave_synth_core.sv | 103 ++++++++++
 tb/tb_wave_synth_core.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/wave_synth_core.sv
// wave_synth_core
// Sample-generation stage that sits after the UART command decoder. A phase
// accumulator advances once per sample tick. From the top 8 bits of the
// accumulator it produces one 8-bit unsigned sample per tick, with an optional
// LFSR white-noise mix. A new waveform selection is only adopted when the phase
// wraps, so the output never jumps in the middle of a period. A change is
// adopted at once while the output is silent or freq_word is 0.
//
// Ports
//   clk             system clock (25 MHz)
//   rst             synchronous reset, active-high
//   wave_select     000 square, 001 saw, 010 triangle, 011 reverse saw, 1xx silence
//   white_noise_en  mix LFSR noise into the sample
//   freq_word       phase increment per sample tick
//   sample          unsigned sample, midscale 8'h80
//   sample_valid    one-cycle strobe; sample was updated this cycle
module wave_synth_core #(
   parameter int unsigned SAMPLE_DIV = 521,
   parameter int unsigned ACC_W      = 24,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       wave_select,
   input  logic             white_noise_en,
   input  logic [ACC_W-1:0] freq_word,
   output logic [7:0]       sample,
   output logic             sample_valid
);

   localparam int unsigned      DIV_W    = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
   // An all-zero LFSR would lock up, so a zero seed falls back to the default.
   localparam logic [15:0]      SEED     = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic [ACC_W-1:0] acc;
   logic [ACC_W:0]   acc_sum;
   logic [15:0]      lfsr;
   logic             lfsr_fb;
   logic [2:0]       active_sel;
   logic             noise_q;
   logic             stage2;
   logic [7:0]       phase;
   logic [7:0]       wave;
   logic [7:0]       mixed;

   // The prescaler counts down from SAMPLE_DIV-1 and ticks at zero. After
   // reset this gives the same tick spacing as an up-counter that starts at 0.
   assign tick    = (div_cnt == '0);
   assign acc_sum = {1'b0, acc} + {1'b0, freq_word};
   assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign phase   = acc[ACC_W-1 -: 8];

   always_comb begin
      wave = 8'h80;
      case (active_sel)
         3'b000:  wave = phase[7] ? 8'h00 : 8'hFF;
         3'b001:  wave = phase;
         3'b010:  wave = phase[7] ? ~{phase[6:0], 1'b0} : {phase[6:0], 1'b0};
         3'b011:  wave = ~phase;
         default: wave = 8'h80;
      endcase
   end

   // Both operands are halved, so the sum is at most 254 and needs no saturation.
   assign mixed = noise_q ? ({1'b0, wave[7:1]} + {1'b0, lfsr[7:1]}) : wave;

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt      <= DIV_LAST;
         acc          <= '0;
         lfsr         <= SEED;
         active_sel   <= 3'b100;
         noise_q      <= 1'b0;
         stage2       <= 1'b0;
         sample       <= 8'h80;
         sample_valid <= 1'b0;
      end else begin
         stage2       <= tick;
         sample_valid <= stage2;
         if (stage2) begin
            sample <= mixed;
         end
         if (tick) begin
            div_cnt <= DIV_LAST;
            acc     <= acc_sum[ACC_W-1:0];
            lfsr    <= {lfsr[14:0], lfsr_fb};
            noise_q <= white_noise_en;
            // Adopt a new waveform on a phase wrap. Also adopt it when the
            // output is silent or stalled, because there is then no period to
            // protect.
            if (acc_sum[ACC_W] || active_sel[2] || (freq_word == '0)) begin
               active_sel <= wave_select;
            end
         end else begin
            div_cnt <= div_cnt - DIV_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_wave_synth_core.sv
module tb_wave_synth_core;

   localparam int SAMPLE_DIV = 4;
   localparam int ACC_W      = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [2:0]       wave_select = 3'b100;
   logic             white_noise_en = 1'b0;
   logic [ACC_W-1:0] freq_word = '0;
   logic [7:0]       sample;
   logic             sample_valid;

   int errors = 0;
   int checks = 0;

   logic [7:0]  last_sample;
   int          m_acc;
   logic [2:0]  m_sel;
   logic [15:0] m_lfsr;
   logic [7:0]  rec [64];

   typedef struct {
      bit         rst_first;
      logic [2:0] sel;
      logic [7:0] fw;
      logic       noise;
      logic [7:0] exp;
   } vec_t;
   vec_t vecs[$];

   wave_synth_core #(.SAMPLE_DIV(SAMPLE_DIV), .ACC_W(ACC_W), .LFSR_SEED(16'hACE1)) dut (
      .clk(clk),
      .rst(rst),
      .wave_select(wave_select),
      .white_noise_en(white_noise_en),
      .freq_word(freq_word),
      .sample(sample),
      .sample_valid(sample_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
      end
   endtask

   function automatic int wave_of(input int sel, input int p);
      case (sel)
         0:       return (p < 128) ? 255 : 0;
         1:       return p;
         2:       return (p < 128) ? 2 * p : 255 - 2 * (p - 128);
         3:       return 255 - p;
         default: return 128;
      endcase
   endfunction

   task automatic model_reset();
      m_acc  = 0;
      m_sel  = 3'b100;
      m_lfsr = 16'hACE1;
   endtask

   task automatic model_tick(input logic [2:0] sel, input int fw, input logic noise,
                             output logic [7:0] exp);
      int sum;
      int w;
      bit wrap;
      sum    = m_acc + fw;
      wrap   = (sum >= 256);
      m_acc  = sum % 256;
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      if (wrap || m_sel >= 3'd4 || fw == 0) m_sel = sel;
      w = wave_of(int'(m_sel), m_acc);
      if (noise) exp = 8'(w / 2 + int'(m_lfsr[7:0]) / 2);
      else       exp = 8'(w);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      last_sample = 8'h80;
   endtask

   task automatic wait_valid(input int budget, output int cycles, output bit ok);
      cycles = 0;
      ok = 1'b0;
      while (cycles < budget) begin
         @(posedge clk);
         #1;
         cycles++;
         if (sample_valid) begin
            ok = 1'b1;
            last_sample = sample;
            return;
         end
         check("hold_between_strobes", int'(sample), int'(last_sample));
      end
      checks++;
      errors++;
      $display("FAIL valid_timeout: got=no strobe expected=strobe within %0d clks", budget);
   endtask

   task automatic add(input bit r, input logic [2:0] s, input logic [7:0] f,
                      input logic n, input logic [7:0] e);
      vecs.push_back('{rst_first: r, sel: s, fw: f, noise: n, exp: e});
   endtask

   initial begin
      int cyc;
      bit ok;
      logic [7:0] exp;

      // Saw 0x10: adopts from silence, wraps back through 0x00.
      for (int i = 1; i <= 17; i++) add(i == 1, 3'b001, 8'h10, 1'b0, 8'((i * 16) % 256));
      // Triangle 0x40, two periods.
      for (int k = 0; k < 2; k++) begin
         add(k == 0, 3'b010, 8'h40, 1'b0, 8'h80);
         add(1'b0,   3'b010, 8'h40, 1'b0, 8'hFF);
         add(1'b0,   3'b010, 8'h40, 1'b0, 8'h7F);
         add(1'b0,   3'b010, 8'h40, 1'b0, 8'h00);
      end
      // Deferred switch saw -> square at the wrap.
      add(1'b1, 3'b001, 8'h40, 1'b0, 8'h40);
      add(1'b0, 3'b000, 8'h40, 1'b0, 8'h80);
      add(1'b0, 3'b000, 8'h40, 1'b0, 8'hC0);
      add(1'b0, 3'b000, 8'h40, 1'b0, 8'hFF);
      add(1'b0, 3'b000, 8'h40, 1'b0, 8'hFF);
      add(1'b0, 3'b000, 8'h40, 1'b0, 8'h00);
      // freq_word == 0 adopts immediately; otherwise wait for the wrap.
      add(1'b1, 3'b011, 8'h00, 1'b0, 8'hFF);
      add(1'b0, 3'b001, 8'h00, 1'b0, 8'h00);
      add(1'b0, 3'b010, 8'h00, 1'b0, 8'h00);
      add(1'b0, 3'b000, 8'h00, 1'b0, 8'hFF);
      add(1'b0, 3'b001, 8'h80, 1'b0, 8'h00);
      add(1'b0, 3'b001, 8'h80, 1'b0, 8'h00);
      add(1'b0, 3'b001, 8'h40, 1'b0, 8'h40);

      // Reset state and strobe timing.
      wave_select = 3'b100; white_noise_en = 1'b0; freq_word = 8'h10;
      do_reset();
      check("reset_sample", int'(sample), 8'h80);
      check("reset_valid", int'(sample_valid), 0);
      wait_valid(20, cyc, ok);
      check("first_valid_latency", cyc, SAMPLE_DIV + 1);
      @(posedge clk); #1;
      check("valid_width", int'(sample_valid), 0);
      wait_valid(20, cyc, ok);
      check("valid_period", cyc + 1, SAMPLE_DIV);

      // Table-driven waveform vectors.
      foreach (vecs[i]) begin
         wave_select = vecs[i].sel;
         freq_word = vecs[i].fw;
         white_noise_en = vecs[i].noise;
         if (vecs[i].rst_first) do_reset();
         wait_valid(10, cyc, ok);
         if (ok) check($sformatf("vec%0d", i), int'(sample), int'(vecs[i].exp));
      end

      // Noise over silence, default seed.
      wave_select = 3'b100; freq_word = 8'h10; white_noise_en = 1'b1;
      do_reset();
      for (int i = 0; i < 64; i++) begin
         wait_valid(10, cyc, ok);
         model_tick(3'b100, 16, 1'b1, exp);
         rec[i] = sample;
         if (ok) check($sformatf("noise%0d", i), int'(sample), int'(exp));
      end

      // Reset in the cycle between tick and strobe kills the strobe.
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_valid", int'(sample_valid), 0);
      check("midrst_sample", int'(sample), 8'h80);
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      last_sample = 8'h80;
      for (int i = 0; i < 64; i++) begin
         wait_valid(10, cyc, ok);
         model_tick(3'b100, 16, 1'b1, exp);
         if (ok) begin
            check($sformatf("noise_repeat%0d", i), int'(sample), int'(rec[i]));
            check($sformatf("noise_model%0d", i), int'(sample), int'(exp));
         end
      end
      white_noise_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wait_valid(10, cyc, ok);
         model_tick(3'b100, 16, 1'b0, exp);
         if (ok) check("silence_no_noise", int'(sample), 8'h80);
      end

      // Random inputs. Junk values are driven away from the tick; the real
      // values are held across the tick.
      do_reset();
      for (int i = 0; i < 300; i++) begin
         logic [2:0] s;
         logic [7:0] f;
         logic       n;
         s = 3'($urandom_range(0, 7));
         f = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         n = 1'($urandom_range(0, 1));
         if (i > 0) begin
            wave_select = 3'($urandom);
            freq_word = 8'($urandom);
            white_noise_en = 1'($urandom);
            @(posedge clk); #1;
         end
         wave_select = s; freq_word = f; white_noise_en = n;
         wait_valid(10, cyc, ok);
         model_tick(s, int'(f), n, exp);
         if (ok) check($sformatf("rand%0d", i), int'(sample), int'(exp));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
